fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Parametrised program-counter and fetch-address generator for the MIPS core; successor to the single-width PC register. It holds the current fetch address and emits it to instruction memory over a valid/ready handshake. It resolves redirects from exception, jump-register, jump and taken branch using a fixed priority. A redirect that arrives while fetch is stalled is buffered and replayed, not dropped. It also captures the exception PC.

## Interface
Parameters:
- ADDR_W, 32, width of every address port and internal PC.
- INC, 1, sequential increment (1 = word-addressed instruction memory, 4 = byte-addressed).
- RESET_VEC, 0, PcOut value while and after Reset.
- EXC_VEC, 32'h80, exception handler address (truncated to ADDR_W).

Ports:
- Clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- Stall  in  1  hazard hold from decode; blocks advance.
- FetchReady  in  1  instruction memory accepts PcOut this cycle.
- FetchValid  out  1  PcOut is a valid fetch address.
- PcOut  out  ADDR_W  current fetch address.
- PcPlusInc  out  ADDR_W  PcOut + INC, combinational; the link value.
- Branch  in  1  branch instruction in execute.
- AluRes  in  1  branch condition true; qualifies Branch.
- Jump  in  1  direct jump; target on Target.
- JumpReg  in  1  register jump; target on RegTarget.
- Target  in  ADDR_W  branch/jump target.
- RegTarget  in  ADDR_W  register-jump target.
- Exception  in  1  exception request; target EXC_VEC.
- EpcOut  out  ADDR_W  PcOut captured at exception.
- RedirectPending  out  1  buffered redirect awaiting advance.

## Operation
- advance = FetchValid & FetchReady & ~Stall.
- New redirect request priority, highest first: Exception > JumpReg > Jump > (Branch & AluRes). Only the highest-priority asserted source is considered.
- Next PC when advance is true:
  - New request present, and its priority ≥ the buffered one (or none buffered): load the new target.
  - Otherwise, if a redirect is buffered: load the buffered target.
  - Otherwise: PcOut + INC.
  - The buffer is cleared in every advance case.
- When advance is false and a new request is present:
  - Buffer it if the buffer is empty, or if its priority ≥ the buffered priority.
  - A strictly lower-priority request is discarded.
  - PcOut holds.
- When advance is false and no request is present: PcOut and the buffer hold.
- Exception sets EpcOut <= PcOut in the cycle Exception is high, independent of advance. The last such cycle wins.
- FetchValid is 0 during Reset and in the first cycle after Reset deasserts. It is 1 from then on.
- Arithmetic is unsigned, modulo 2^ADDR_W. PcOut = 2^ADDR_W − INC followed by an advance wraps to 0.
- Targets are used verbatim; no alignment check.
- Reset values: PcOut = RESET_VEC, EpcOut = 0, FetchValid = 0, RedirectPending = 0, buffer priority = NONE.
- Reset mid-operation: Reset overrides everything in the same edge and discards any buffered redirect.

## Timing
- Redirect latency: a request sampled with advance = 1 appears on PcOut after the next posedge (1 cycle).
- A buffered redirect appears 1 cycle after the first advance.
- PcPlusInc and RedirectPending are combinational from registered state only. They have no input-to-output path.
- Handshake: PcOut and FetchValid stay stable while FetchValid & ~FetchReady.
- Simultaneous Stall and redirect: the redirect is buffered and PcOut holds.

## Structure
- Package pc_pkg holds:
  - redirect_pri_t enum: PRI_NONE, PRI_BRANCH, PRI_JUMP, PRI_JUMPREG, PRI_EXC, ordered so numeric compare gives priority.
  - pri_select function: returns the priority and target from the request inputs.
- Sub-module pc_redirect_buffer holds the 1-entry pending register: valid, priority, address, with the overwrite/clear rules above.
- The top level holds the PC register, the next-PC mux, EpcOut and the FetchValid flop.

## Test plan
- Reset/sequential: Reset high 2 cycles then low, FetchReady = 1, INC = 1 → FetchValid 0 for 1 cycle after release, then PcOut 0, 1, 2, 3. Repeat with INC = 4 → 0, 4, 8.
- Priority: at PcOut = 5, assert Exception, JumpReg (RegTarget = 0x40), Jump (Target = 0x20) and Branch & AluRes together → PcOut = 0x80 next cycle, EpcOut = 5. Repeat with Jump, Branch and AluRes only → PcOut = 0x20.
- Stalled redirect: Stall = 1 for 3 cycles with Jump to 0x30 in cycle 1 only → PcOut holds, RedirectPending = 1. After Stall drops → PcOut = 0x30, then 0x31, and RedirectPending = 0.
- Buffer overwrite: while FetchReady = 0, Branch & AluRes to 0x10, then JumpReg to 0x50, then Jump to 0x60 → 0x50 is kept. On FetchReady = 1 → PcOut = 0x50.
- Wrap: ADDR_W = 8, INC = 1, force PcOut = 0xFF via Jump → next advance PcOut = 0x00, and PcPlusInc = 0x00 while PcOut = 0xFF.
- Reset mid-operation: buffered redirect present, assert Reset → PcOut = RESET_VEC, RedirectPending = 0, EpcOut = 0, and the buffered target is never fetched.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the fetch PC unit: redirect priority encoding and the
// request selector used by both the PC mux and the redirect buffer.
package pc_pkg;

  localparam int MAX_ADDR_W = 64;

  // Numeric order is priority order, so a plain compare ranks two requests.
  typedef enum logic [2:0] {
    PRI_NONE    = 3'd0,
    PRI_BRANCH  = 3'd1,
    PRI_JUMP    = 3'd2,
    PRI_JUMPREG = 3'd3,
    PRI_EXC     = 3'd4
  } redirect_pri_t;

  typedef struct packed {
    redirect_pri_t               pri;
    logic [MAX_ADDR_W-1:0]       target;
  } redirect_req_t;

  function automatic redirect_req_t pri_select(
    input logic                  exception,
    input logic                  jumpReg,
    input logic                  jump,
    input logic                  branch,
    input logic                  aluRes,
    input logic [MAX_ADDR_W-1:0] excVec,
    input logic [MAX_ADDR_W-1:0] regTarget,
    input logic [MAX_ADDR_W-1:0] target
  );
    redirect_req_t req;
    req.pri    = PRI_NONE;
    req.target = '0;
    if (exception) begin
      req.pri    = PRI_EXC;
      req.target = excVec;
    end else if (jumpReg) begin
      req.pri    = PRI_JUMPREG;
      req.target = regTarget;
    end else if (jump) begin
      req.pri    = PRI_JUMP;
      req.target = target;
    end else if (branch && aluRes) begin
      req.pri    = PRI_BRANCH;
      req.target = target;
    end
    return req;
  endfunction

endpackage

// File: rtl/pc_redirect_buffer.sv
// One-entry holding register for a redirect that arrives while fetch cannot
// advance; a later request replaces it only if it is at least as urgent.
module pc_redirect_buffer
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              advance,
  input  redirect_pri_t     newPri,
  input  logic [ADDR_W-1:0] newTarget,
  output logic              valid,
  output redirect_pri_t     pri,
  output logic [ADDR_W-1:0] target
);

  // Any advance consumes the entry, whether or not it was the one taken.
  always_ff @(posedge Clk) begin
    if (Reset || advance) begin
      valid <= 1'b0;
      pri   <= PRI_NONE;
    end else if ((newPri != PRI_NONE) && (!valid || (newPri >= pri))) begin
      valid  <= 1'b1;
      pri    <= newPri;
      target <= newTarget;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch-address generator: PC register, prioritised
// redirect mux with stall buffering, exception PC capture and fetch-valid flop.
module fetch_pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INC       = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h80)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              FetchReady,
  output logic              FetchValid,
  output logic [ADDR_W-1:0] PcOut,
  output logic [ADDR_W-1:0] PcPlusInc,
  input  logic              Branch,
  input  logic              AluRes,
  input  logic              Jump,
  input  logic              JumpReg,
  input  logic [ADDR_W-1:0] Target,
  input  logic [ADDR_W-1:0] RegTarget,
  input  logic              Exception,
  output logic [ADDR_W-1:0] EpcOut,
  output logic              RedirectPending
);

  redirect_req_t     req;
  redirect_pri_t     bufPri;
  logic              bufValid;
  logic [ADDR_W-1:0] bufTarget;
  logic [ADDR_W-1:0] reqTarget;
  logic [ADDR_W-1:0] nextPc;
  logic              advance;
  logic              takeNew;
  logic              unusedReqHi;

  always_comb begin
    req = pri_select(Exception, JumpReg, Jump, Branch, AluRes,
                     MAX_ADDR_W'(EXC_VEC), MAX_ADDR_W'(RegTarget),
                     MAX_ADDR_W'(Target));
  end

  // The selector works at the widest address; only ADDR_W bits matter here.
  assign reqTarget   = req.target[ADDR_W-1:0];
  assign unusedReqHi = ^req.target;

  assign advance         = FetchValid & FetchReady & ~Stall;
  assign takeNew         = (req.pri != PRI_NONE) && (!bufValid || (req.pri >= bufPri));
  assign PcPlusInc       = PcOut + ADDR_W'(INC);
  assign RedirectPending = bufValid;

  always_comb begin
    nextPc = PcPlusInc;
    if (takeNew) begin
      nextPc = reqTarget;
    end else if (bufValid) begin
      nextPc = bufTarget;
    end
  end

  pc_redirect_buffer #(.ADDR_W(ADDR_W)) u_buffer (
    .Clk       (Clk),
    .Reset     (Reset),
    .advance   (advance),
    .newPri    (req.pri),
    .newTarget (reqTarget),
    .valid     (bufValid),
    .pri       (bufPri),
    .target    (bufTarget)
  );

  // EpcOut tracks the PC of any exception cycle, even one that cannot advance.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PcOut      <= RESET_VEC;
      EpcOut     <= '0;
      FetchValid <= 1'b0;
    end else begin
      FetchValid <= 1'b1;
      if (advance) begin
        PcOut <= nextPc;
      end
      if (Exception) begin
        EpcOut <= PcOut;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: three parameterisations share one
// stimulus stream and are compared against an abstract model every cycle.
module tb_fetch_pc_unit;

  typedef struct {
    bit          reset, stall, ready, branch, aluRes, jump, jumpReg, exception;
    logic [31:0] target, regTarget;
  } stim_t;

  typedef struct {
    longint unsigned pc, epc, btgt;
    bit              fv, pend;
    int              bpri;
  } model_t;

  typedef struct {
    stim_t           s;
    longint unsigned expPc, expEpc;
    bit              expFv, expPend;
    string           name;
  } vec_t;

  logic        Clk;
  logic        reset, stall, ready, branch, aluRes, jump, jumpReg, exception;
  logic [31:0] target, regTarget;

  logic        fvA, pendA, fvB, pendB, fvC, pendC;
  logic [31:0] pcA, ppA, epcA, pcB, ppB, epcB;
  logic [7:0]  pcC, ppC, epcC;

  int          total = 0;
  int          bad   = 0;
  model_t      mdl[3];
  int unsigned awTab[3]  = '{32, 32, 8};
  int unsigned incTab[3] = '{1, 4, 1};
  vec_t        vecs[$];

  fetch_pc_unit #(.ADDR_W(32), .INC(1)) dutA (
    .Clk(Clk), .Reset(reset), .Stall(stall), .FetchReady(ready),
    .FetchValid(fvA), .PcOut(pcA), .PcPlusInc(ppA),
    .Branch(branch), .AluRes(aluRes), .Jump(jump), .JumpReg(jumpReg),
    .Target(target), .RegTarget(regTarget), .Exception(exception),
    .EpcOut(epcA), .RedirectPending(pendA)
  );

  fetch_pc_unit #(.ADDR_W(32), .INC(4)) dutB (
    .Clk(Clk), .Reset(reset), .Stall(stall), .FetchReady(ready),
    .FetchValid(fvB), .PcOut(pcB), .PcPlusInc(ppB),
    .Branch(branch), .AluRes(aluRes), .Jump(jump), .JumpReg(jumpReg),
    .Target(target), .RegTarget(regTarget), .Exception(exception),
    .EpcOut(epcB), .RedirectPending(pendB)
  );

  fetch_pc_unit #(.ADDR_W(8), .INC(1), .RESET_VEC(8'h00), .EXC_VEC(8'h80)) dutC (
    .Clk(Clk), .Reset(reset), .Stall(stall), .FetchReady(ready),
    .FetchValid(fvC), .PcOut(pcC), .PcPlusInc(ppC),
    .Branch(branch), .AluRes(aluRes), .Jump(jump), .JumpReg(jumpReg),
    .Target(target[7:0]), .RegTarget(regTarget[7:0]), .Exception(exception),
    .EpcOut(epcC), .RedirectPending(pendC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference behaviour: pick the most urgent request, then decide between
  // taking it, replaying the held one, stepping sequentially or holding.
  function automatic model_t modelStep(model_t m, stim_t s, int unsigned aw, int unsigned inc);
    longint unsigned mask = (64'd1 << aw) - 64'd1;
    int              pris[4] = '{4, 3, 2, 1};
    bit              hits[4];
    longint unsigned tgts[4];
    int              reqPri = 0;
    longint unsigned reqTgt = 0;
    model_t          n = m;
    bit              adv;
    hits = '{s.exception, s.jumpReg, s.jump, s.branch && s.aluRes};
    tgts = '{64'h80, 64'(s.regTarget), 64'(s.target), 64'(s.target)};
    for (int k = 3; k >= 0; k--) begin
      if (hits[k]) begin
        reqPri = pris[k];
        reqTgt = tgts[k] & mask;
      end
    end
    if (s.reset) begin
      n.pc = 0; n.epc = 0; n.fv = 0; n.pend = 0; n.bpri = 0;
      return n;
    end
    adv  = m.fv && s.ready && !s.stall;
    n.fv = 1;
    if (s.exception) n.epc = m.pc;
    if (adv) begin
      if (reqPri > 0 && (!m.pend || reqPri >= m.bpri)) n.pc = reqTgt;
      else if (m.pend) n.pc = m.btgt;
      else n.pc = (m.pc + inc) & mask;
      n.pend = 0;
      n.bpri = 0;
    end else if (reqPri > 0 && (!m.pend || reqPri >= m.bpri)) begin
      n.pend = 1;
      n.bpri = reqPri;
      n.btgt = reqTgt;
    end
    return n;
  endfunction

  function automatic stim_t mk(bit rst, bit stl, bit rdy, bit br, bit alu, bit jmp,
                               bit jr, bit exc, logic [31:0] tgt, logic [31:0] rtgt);
    stim_t s;
    s.reset = rst; s.stall = stl; s.ready = rdy; s.branch = br; s.aluRes = alu;
    s.jump = jmp; s.jumpReg = jr; s.exception = exc; s.target = tgt; s.regTarget = rtgt;
    return s;
  endfunction

  function automatic void addVec(stim_t s, longint unsigned pc, longint unsigned epc,
                                 bit fv, bit pend, string name);
    vec_t v;
    v.s = s; v.expPc = pc; v.expEpc = epc; v.expFv = fv; v.expPend = pend; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the models.
  task automatic applyStimulus(stim_t s);
    reset = s.reset; stall = s.stall; ready = s.ready; branch = s.branch;
    aluRes = s.aluRes; jump = s.jump; jumpReg = s.jumpReg; exception = s.exception;
    target = s.target; regTarget = s.regTarget;
    @(posedge Clk);
    for (int k = 0; k < 3; k++) mdl[k] = modelStep(mdl[k], s, awTab[k], incTab[k]);
    #1;
  endtask

  task automatic compareInst(int idx, string tag, logic fv, logic [63:0] pc,
                             logic [63:0] pp, logic [63:0] epc, logic pend);
    longint unsigned mask = (64'd1 << awTab[idx]) - 64'd1;
    checkVal($sformatf("%s/i%0d/FetchValid", tag, idx), 64'(fv), 64'(mdl[idx].fv));
    checkVal($sformatf("%s/i%0d/PcOut", tag, idx), pc, mdl[idx].pc);
    checkVal($sformatf("%s/i%0d/PcPlusInc", tag, idx), pp, (mdl[idx].pc + incTab[idx]) & mask);
    checkVal($sformatf("%s/i%0d/EpcOut", tag, idx), epc, mdl[idx].epc);
    checkVal($sformatf("%s/i%0d/RedirectPending", tag, idx), 64'(pend), 64'(mdl[idx].pend));
  endtask

  task automatic checkOutput(string tag);
    compareInst(0, tag, fvA, 64'(pcA), 64'(ppA), 64'(epcA), pendA);
    compareInst(1, tag, fvB, 64'(pcB), 64'(ppB), 64'(epcB), pendB);
    compareInst(2, tag, fvC, 64'(pcC), 64'(ppC), 64'(epcC), pendC);
  endtask

  initial begin
    stim_t plain;
    stim_t rnd;
    plain = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      mdl[k].pc = 0; mdl[k].epc = 0; mdl[k].btgt = 0;
      mdl[k].fv = 0; mdl[k].pend = 0; mdl[k].bpri = 0;
    end

    // Directed vectors; expected values refer to the INC=1, 32-bit instance.
    addVec(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, "reset0");
    addVec(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, "reset1");
    addVec(plain, 0, 0, 1, 0, "release");
    addVec(plain, 1, 0, 1, 0, "seq1");
    addVec(plain, 2, 0, 1, 0, "seq2");
    addVec(plain, 3, 0, 1, 0, "seq3");
    addVec(plain, 4, 0, 1, 0, "seq4");
    addVec(plain, 5, 0, 1, 0, "seq5");
    addVec(mk(0, 0, 1, 1, 1, 1, 1, 1, 32'h20, 32'h40), 32'h80, 5, 1, 0, "prioAll");
    addVec(mk(0, 0, 1, 1, 1, 1, 0, 0, 32'h20, 0), 32'h20, 5, 1, 0, "prioJump");
    addVec(plain, 32'h21, 5, 1, 0, "afterJump");
    addVec(mk(0, 1, 1, 0, 0, 1, 0, 0, 32'h30, 0), 32'h21, 5, 1, 1, "stallJump");
    addVec(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 32'h21, 5, 1, 1, "stallHold1");
    addVec(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 32'h21, 5, 1, 1, "stallHold2");
    addVec(plain, 32'h30, 5, 1, 0, "replay");
    addVec(plain, 32'h31, 5, 1, 0, "postReplay");
    addVec(mk(0, 0, 0, 1, 1, 0, 0, 0, 32'h10, 0), 32'h31, 5, 1, 1, "bufBranch");
    addVec(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h50), 32'h31, 5, 1, 1, "bufJumpReg");
    addVec(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h60, 0), 32'h31, 5, 1, 1, "bufJumpLower");
    addVec(plain, 32'h50, 5, 1, 0, "bufDrain");
    addVec(plain, 32'h51, 5, 1, 0, "postDrain");
    addVec(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h70, 0), 32'h51, 5, 1, 1, "bufBeforeReset");
    addVec(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, "midReset");
    addVec(plain, 0, 0, 1, 0, "midRelease");
    addVec(plain, 1, 0, 1, 0, "noStaleReplay");
    addVec(plain, 2, 0, 1, 0, "seqAgain");
    addVec(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0), 2, 2, 1, 1, "stallExc");
    addVec(plain, 32'h80, 2, 1, 0, "excReplay");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      checkOutput(vecs[i].name);
      checkVal({vecs[i].name, "/tbl/PcOut"}, 64'(pcA), vecs[i].expPc);
      checkVal({vecs[i].name, "/tbl/FetchValid"}, 64'(fvA), 64'(vecs[i].expFv));
      checkVal({vecs[i].name, "/tbl/Pending"}, 64'(pendA), 64'(vecs[i].expPend));
      checkVal({vecs[i].name, "/tbl/EpcOut"}, 64'(epcA), vecs[i].expEpc);
    end

    // Byte-addressed instance steps by four after reset.
    applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    checkVal("inc4/fvAfterReset", 64'(fvB), 64'd0);
    applyStimulus(plain);
    checkVal("inc4/pc0", 64'(pcB), 64'd0);
    checkVal("inc4/fv", 64'(fvB), 64'd1);
    applyStimulus(plain);
    checkVal("inc4/pc4", 64'(pcB), 64'd4);
    applyStimulus(plain);
    checkVal("inc4/pc8", 64'(pcB), 64'd8);
    checkOutput("inc4");

    // 8-bit instance wraps from the top address back to zero.
    applyStimulus(mk(0, 0, 1, 0, 0, 1, 0, 0, 32'hFF, 0));
    checkVal("wrap/pcFF", 64'(pcC), 64'hFF);
    checkVal("wrap/plusInc", 64'(ppC), 64'h00);
    applyStimulus(plain);
    checkVal("wrap/pc00", 64'(pcC), 64'h00);
    checkOutput("wrap");

    // Random traffic against the model on all three instances.
    for (int c = 0; c < 1500; c++) begin
      rnd.reset     = ($urandom_range(0, 49) == 0);
      rnd.stall     = ($urandom_range(0, 3) == 0);
      rnd.ready     = ($urandom_range(0, 9) < 7);
      rnd.branch    = ($urandom_range(0, 4) == 0);
      rnd.aluRes    = ($urandom_range(0, 1) == 0);
      rnd.jump      = ($urandom_range(0, 7) == 0);
      rnd.jumpReg   = ($urandom_range(0, 9) == 0);
      rnd.exception = ($urandom_range(0, 19) == 0);
      rnd.target    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                                  : 32'($urandom);
      rnd.regTarget = 32'($urandom);
      applyStimulus(rnd);
      checkOutput($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
